adam_periph_spi_fifo: RTL
=========================

Name: adam_periph_spi_fifo

Overview:
- Synchronous stream FIFO that buffers words between the SPI register/bus front-end and the SPI PHY.
- One instance on the TX path feeds PHY tx/tx_valid/tx_ready. One instance on the RX path consumes PHY rx/rx_valid/rx_ready.
- Honours the peripheral pause protocol. Flush is permitted only while paused, matching the config-change-while-paused rule used across the SPI peripheral.

Parameters:
- DATA_WIDTH, 32, word width; must match the PHY DATA_WIDTH.
- DEPTH, 8, number of entries; power of two, at least 2.
- LEVEL_WIDTH, $clog2(DEPTH)+1, dependent; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pause_req  in  1  pause request
- pause_ack  out  1  pause acknowledge
- flush  in  1  empty the FIFO; honoured only while pause_req && pause_ack
- in_data  in  DATA_WIDTH  write word
- in_valid  in  1  write valid
- in_ready  out  1  write ready
- out_data  out  DATA_WIDTH  read word
- out_valid  out  1  read valid
- out_ready  in  1  read ready
- level  out  LEVEL_WIDTH  current occupancy, 0..DEPTH
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- threshold  in  LEVEL_WIDTH  watermark; present only with the optional feature
- thr_hit  out  1  watermark flag; present only with the optional feature

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: pointers 0, level 0, empty 1, full 0, out_valid 0, out_data 0, in_ready 0, pause_ack 0, thr_hit 0.
- Storage: register array, write pointer and read pointer of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH naturally. level is a separate counter.
- in_ready: registered. Equals !full_next && !pause_req, so it is 1 the cycle after reset release when not paused.
- Push: occurs when in_valid && in_ready. Data is written at wptr, and wptr increments.
- Output stage: registered, first-word-fall-through.
  - A word pushed into an empty FIFO appears on out_data with out_valid=1 exactly 1 cycle after the push.
  - Pop occurs when out_valid && out_ready. The next word is presented the following cycle with no bubble while level > 1.
- Stream rules:
  - Once out_valid=1, it and out_data hold until the handshake completes.
  - in_ready may drop at any time.
- Simultaneous push and pop: level is unchanged, both pointers advance.
  - At full, in_ready=0, so no push occurs.
  - At empty, the pop is impossible because out_valid=0.
- Pause:
  - pause_req=1 drops in_ready on the next cycle.
  - No new word is loaded into the output stage. A word already shown with out_valid=1 stays until popped.
  - pause_ack rises the cycle after pause_req=1 with out_valid=0 or a completing pop.
  - pause_ack falls the cycle after pause_req=0, and normal operation resumes the cycle after that.
  - Contents are retained across a pause.
- Flush: effective only when pause_req && pause_ack. Pointers, level and out_valid are zeroed in 1 cycle. Otherwise flush is ignored.
- Reset mid-transfer: all contents are discarded and the FIFO returns to the reset values.

Optional Feature:
- Macro: ADAM_SPI_FIFO_THRESHOLD_EN.
- Defined:
  - threshold and thr_hit ports exist.
  - thr_hit is registered and equals level >= threshold, updated each cycle from the post-update level.
  - Intended as the TX-low / RX-high interrupt source; the TX instance wires the inverted sense externally.
- Undefined:
  - Both ports are absent and no comparator is built.

Decomposition:
- Shared package adam_periph_spi_pkg holds:
  - default DATA_WIDTH and DEPTH constants;
  - a level_t typedef helper;
  - status bit index constants (EMPTY, FULL, THR) for the register block.
- One sub-module is natural: adam_periph_spi_fifo_mem, a plain DEPTH x DATA_WIDTH register array with one write port and one asynchronous read port.

Test Plan:
- Reset then push 0xA5A5_0001 with out_ready=0 -> out_valid=1 one cycle later, out_data=0xA5A5_0001, level=1, empty=0.
- Push 8 words 0..7 with DEPTH=8 -> full=1, in_ready=0, level=8. Continuous out_ready=1 -> outputs 0..7 in order on consecutive cycles, then empty=1.
- Push and pop every cycle from level=3 -> level stays 3 and data order is preserved.
- out_valid=1 with out_ready=0, then pause_req=1 -> pause_ack stays 0 and out_data is held. Raise out_ready -> pause_ack=1 on the next cycle and in_ready=0.
- Paused with level=5, pulse flush -> level=0, empty=1 next cycle. flush with pause_req=0 -> no effect.
- With ADAM_SPI_FIFO_THRESHOLD_EN defined and threshold=4: push 3 words -> thr_hit=0; push a 4th -> thr_hit=1 the cycle after; pop 1 -> thr_hit=0.

Source files
------------

// File: rtl/adam_periph_spi_pkg.sv
// Shared constants and helpers for the SPI peripheral FIFO slice.
package adam_periph_spi_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;

    typedef logic [$clog2(DEF_DEPTH):0] level_t;

    // Status register bit positions used by the register block
    localparam int EMPTY = 0;
    localparam int FULL  = 1;
    localparam int THR   = 2;

endpackage

// File: rtl/adam_periph_spi_fifo_mem.sv
// DEPTH x DATA_WIDTH register array, one write port, async read port.
module adam_periph_spi_fifo_mem
    import adam_periph_spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/adam_periph_spi_fifo.sv
// SPI stream FIFO with registered FWFT output and pause/flush support.
// Optional watermark flag enabled by ADAM_SPI_FIFO_THRESHOLD_EN.
module adam_periph_spi_fifo
    import adam_periph_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pause_req,
    output logic                   pause_ack,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef ADAM_SPI_FIFO_THRESHOLD_EN
    input  logic [LEVEL_WIDTH-1:0] threshold,
    output logic                   thr_hit,
`endif
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [AW-1:0]          rd_addr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [LEVEL_WIDTH-1:0] level_upd;
    logic [LEVEL_WIDTH-1:0] stored;
    logic                   push;
    logic                   pop;
    logic                   flush_eff;
    logic                   load;
    logic                   has_stored;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign flush_eff = flush && pause_req && pause_ack;

    // level counts the word on display too; stored excludes it
    assign stored     = level - LEVEL_WIDTH'(out_valid);
    assign has_stored = stored != '0;
    assign load       = (!out_valid || pop) && !pause_req;
    assign rd_addr    = rptr + AW'(pop);

    always_comb begin
        level_upd = level;
        if (flush_eff) begin
            level_upd = '0;
        end else if (push && !pop) begin
            level_upd = level + 1'b1;
        end else if (pop && !push) begin
            level_upd = level - 1'b1;
        end
    end

    adam_periph_spi_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b0;
            pause_ack <= 1'b0;
        end else begin
            level     <= level_upd;
            in_ready  <= (level_upd != LEVEL_WIDTH'(DEPTH)) && !pause_req;
            pause_ack <= pause_req && (!out_valid || pop);
            if (flush_eff) begin
                wptr      <= '0;
                rptr      <= '0;
                out_valid <= 1'b0;
            end else begin
                if (push) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                // Empty FIFO: bypass the pushed word straight to the output
                if (load) begin
                    out_valid <= has_stored || push;
                    if (has_stored) begin
                        out_data <= rd_data;
                    end else if (push) begin
                        out_data <= in_data;
                    end
                end else if (pop) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign full  = level == LEVEL_WIDTH'(DEPTH);
    assign empty = level == '0;

`ifdef ADAM_SPI_FIFO_THRESHOLD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_hit <= 1'b0;
        end else begin
            thr_hit <= level_upd >= threshold;
        end
    end
`endif

endmodule
